// File: rtl/alu_cu_pkg.sv
// rtl/alu_cu_pkg.sv - opcodes, FSM states, instruction field positions and decode helpers
package alu_cu_pkg;

    localparam logic [5:0] OP_LDI = 6'b000001;
    localparam logic [5:0] OP_ADD = 6'b010000;
    localparam logic [5:0] OP_SUB = 6'b010001;
    localparam logic [5:0] OP_EQ  = 6'b100000;
    localparam logic [5:0] OP_NE  = 6'b100001;
    localparam logic [5:0] OP_LE  = 6'b100010;
    localparam logic [5:0] OP_GT  = 6'b100011;
    localparam logic [5:0] OP_SHL = 6'b110000;
    localparam logic [5:0] OP_SHR = 6'b110001;
    localparam logic [5:0] OP_SRA = 6'b110010;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RD_LSB  = 21;
    localparam int RS1_LSB = 16;
    localparam int RS2_LSB = 11;
    localparam int IMM_MSB = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    function automatic logic is_alu_op(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_EQ, OP_NE, OP_LE, OP_GT,
            OP_SHL, OP_SHR, OP_SRA: return 1'b1;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [5:0] op);
        return is_alu_op(op) || (op == OP_LDI);
    endfunction

    // Only the arithmetic ops own the carry; compares and shifts leave C alone.
    function automatic logic updates_c(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_cu_sequencer_if.sv
// rtl/alu_cu_sequencer_if.sv - instruction handshake, ALU port and status bundle
interface alu_cu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [5:0]  alu_op;
    logic        alu_cin;
    logic [31:0] alu_res;
    logic        alu_cout;
    logic        alu_z;
    logic        alu_n;
    logic        done;
    logic        err;
    logic [2:0]  flags;

    modport slave (
        input  instr_valid, instr, alu_res, alu_cout, alu_z, alu_n,
        output instr_ready, alu_a, alu_b, alu_op, alu_cin, done, err, flags
    );

    modport master (
        output instr_valid, instr, alu_res, alu_cout, alu_z, alu_n,
        input  instr_ready, alu_a, alu_b, alu_op, alu_cin, done, err, flags
    );
endinterface

// File: rtl/cu_regfile.sv
// rtl/cu_regfile.sv - 2R1W register file with debug port; CU_R0_ZERO_EN hardwires register 0
module cu_regfile #(
    parameter int REG_COUNT = 8,
    parameter int REG_AW    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [31:0]       rdata1,
    output logic [31:0]       rdata2,
    output logic [31:0]       dbg_data
);
`ifdef CU_R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    logic [31:0] regs [REG_COUNT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (we && !(R0_ZERO && waddr == '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1   = (R0_ZERO && raddr1   == '0) ? '0 : regs[raddr1];
    assign rdata2   = (R0_ZERO && raddr2   == '0) ? '0 : regs[raddr2];
    assign dbg_data = (R0_ZERO && dbg_addr == '0) ? '0 : regs[dbg_addr];
endmodule

// File: rtl/alu_cu_sequencer.sv
// rtl/alu_cu_sequencer.sv - 4-edge IDLE/DECODE/EXEC/WB control unit in front of the 32-bit ALU (option CU_R0_ZERO_EN)
module alu_cu_sequencer
    import alu_cu_pkg::*;
#(
    parameter int REG_COUNT = 8,
    parameter int REG_AW    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_cu_sequencer_if.slave   bus,
    input  logic [REG_AW-1:0]   dbg_addr,
    output logic [31:0]         dbg_data
);
    state_t      state, state_nxt;
    logic [31:0] ir;
    logic [31:0] res_q;
    logic        cout_q, z_q, n_q;
    logic [31:0] a_q, b_q;
    logic [5:0]  op_q;
    logic [2:0]  flags_q;
    logic        done_q, err_q;
    logic [31:0] rdata1, rdata2, wdata;
    logic        we;
    logic        unused_ir;

    logic [5:0]        op;
    logic [REG_AW-1:0] rd, rs1, rs2;

    assign op  = ir[OP_MSB:OP_LSB];
    assign rd  = ir[RD_LSB  +: REG_AW];
    assign rs1 = ir[RS1_LSB +: REG_AW];
    assign rs2 = ir[RS2_LSB +: REG_AW];
    assign unused_ir = ^ir;

    assign we    = (state == ST_WB) && is_legal(op);
    assign wdata = (op == OP_LDI) ? {16'h0000, ir[IMM_MSB:0]} : res_q;

    cu_regfile #(.REG_COUNT(REG_COUNT), .REG_AW(REG_AW)) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (rd),
        .wdata    (wdata),
        .raddr1   (rs1),
        .raddr2   (rs2),
        .dbg_addr (dbg_addr),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Illegal opcodes skip EXEC so the ALU outputs are never sampled for them.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (bus.instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: state_nxt = is_legal(op) ? ST_EXEC : ST_WB;
            ST_EXEC:   state_nxt = ST_WB;
            ST_WB:     state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            flags_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= (state == ST_WB) &&  is_legal(op);
            err_q  <= (state == ST_WB) && !is_legal(op);
            case (state)
                ST_IDLE: if (bus.instr_valid) ir <= bus.instr;
                ST_DECODE: if (is_alu_op(op)) begin
                    a_q  <= rdata1;
                    b_q  <= rdata2;
                    op_q <= op;
                end
                ST_EXEC: begin
                    res_q  <= bus.alu_res;
                    cout_q <= bus.alu_cout;
                    z_q    <= bus.alu_z;
                    n_q    <= bus.alu_n;
                end
                ST_WB: if (is_alu_op(op)) begin
                    flags_q[0] <= z_q;
                    flags_q[1] <= n_q;
                    if (updates_c(op)) flags_q[2] <= cout_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_ready = (state == ST_IDLE);
    assign bus.alu_a       = a_q;
    assign bus.alu_b       = b_q;
    assign bus.alu_op      = op_q;
    assign bus.alu_cin     = flags_q[2];
    assign bus.flags       = flags_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_alu_cu_sequencer.sv
// tb/tb_alu_cu_sequencer.sv - scoreboard bench for alu_cu_sequencer with a behavioural ALU
module tb_alu_cu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [2:0]  mon_sel = '0;
    logic [2:0]  tb_sel = '0;
    logic        mon_act = 1'b0;
    logic [32:0] alu_t;
    int          checks = 0;
    int          errors = 0;
    int          issued = 0;
    int          hs = 0;

`ifdef CU_R0_ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    typedef struct {
        logic        is_err;
        logic [2:0]  rg;
        logic [31:0] val;
        logic [2:0]  fl;
        logic        ca;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
    } exp_t;

    exp_t sb[$];

    alu_cu_sequencer_if bus();

    alu_cu_sequencer #(.REG_COUNT(8), .REG_AW(3)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    assign dbg_addr = mon_act ? mon_sel : tb_sel;

    always #5 clk = ~clk;

    always_comb begin
        alu_t        = '0;
        bus.alu_res  = '0;
        bus.alu_cout = 1'b0;
        case (bus.alu_op)
            6'b010000: begin
                alu_t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'b0, bus.alu_cin};
                bus.alu_res = alu_t[31:0]; bus.alu_cout = alu_t[32];
            end
            6'b010001: begin
                alu_t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {32'b0, bus.alu_cin};
                bus.alu_res = alu_t[31:0]; bus.alu_cout = alu_t[32];
            end
            6'b100000: bus.alu_res = {31'b0, bus.alu_a == bus.alu_b};
            6'b100001: bus.alu_res = {31'b0, bus.alu_a != bus.alu_b};
            6'b100010: bus.alu_res = {31'b0, $signed(bus.alu_a) <= $signed(bus.alu_b)};
            6'b100011: bus.alu_res = {31'b0, $signed(bus.alu_a) >  $signed(bus.alu_b)};
            6'b110000: bus.alu_res = bus.alu_a << bus.alu_b[4:0];
            6'b110001: bus.alu_res = bus.alu_a >> bus.alu_b[4:0];
            6'b110010: bus.alu_res = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
            default:   bus.alu_res = '0;
        endcase
        bus.alu_z = (bus.alu_res == 32'd0);
        bus.alu_n = bus.alu_res[31];
    end

    always @(posedge clk) if (rst_n && bus.instr_valid && bus.instr_ready) hs++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
        return {op, rd, rs1, rs2, 11'b0};
    endfunction

    function automatic logic [31:0] i_ins(input logic [4:0] rd, input logic [15:0] imm);
        return {6'b000001, rd, 5'd0, imm};
    endfunction

    function automatic exp_t e_ldi(input logic [2:0] rg, input logic [31:0] val, input logic [2:0] fl);
        exp_t e;
        e = '{is_err: 1'b0, rg: rg, val: val, fl: fl, ca: 1'b0, a: '0, b: '0, op: '0};
        return e;
    endfunction

    function automatic exp_t e_alu(input logic [2:0] rg, input logic [31:0] val, input logic [2:0] fl,
                                   input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
        exp_t e;
        e = '{is_err: 1'b0, rg: rg, val: val, fl: fl, ca: 1'b1, a: a, b: b, op: op};
        return e;
    endfunction

    task automatic issue(input logic [31:0] w, input exp_t e, input bit push);
        int n = 0;
        @(negedge clk);
        while (!bus.instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instr_ready) check("ready_timeout", 32'(bus.instr_ready), 32'd1);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        if (push) sb.push_back(e);
        issued++;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
    endtask

    // Monitor: every retirement pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done || bus.err) begin
                if (sb.size() == 0) begin
                    check("unexpected_retire", {30'b0, bus.err, bus.done}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("retire_err",  32'(bus.err),  32'(e.is_err));
                    check("retire_done", 32'(bus.done), 32'(!e.is_err));
                    check("flags", 32'(bus.flags), 32'(e.fl));
                    if (e.ca) begin
                        check("alu_a",  bus.alu_a, e.a);
                        check("alu_b",  bus.alu_b, e.b);
                        check("alu_op", 32'(bus.alu_op), 32'(e.op));
                    end
                    mon_sel = e.rg;
                    mon_act = 1'b1;
                    #1 check("reg_value", dbg_data, e.val);
                    mon_act = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        #12;
        check("rst_ready", 32'(bus.instr_ready), 32'd1);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_err",   32'(bus.err), 32'd0);
        check("rst_flags", 32'(bus.flags), 32'd0);
        check("rst_alu_a", bus.alu_a, 32'd0);
        tb_sel = 3'd1;
        #1 check("rst_r1", dbg_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        issue(i_ins(5'd1, 16'h0005), e_ldi(3'd1, 32'd5, 3'b000), 1'b1);
        issue(i_ins(5'd2, 16'h0003), e_ldi(3'd2, 32'd3, 3'b000), 1'b1);
        issue(r_ins(6'b010000, 5'd3, 5'd1, 5'd2), e_alu(3'd3, 32'd8, 3'b000, 32'd5, 32'd3, 6'b010000), 1'b1);
        issue(i_ins(5'd4, 16'hFFFF), e_ldi(3'd4, 32'h0000FFFF, 3'b000), 1'b1);
        issue(i_ins(5'd5, 16'h0010), e_ldi(3'd5, 32'd16, 3'b000), 1'b1);
        issue(r_ins(6'b110000, 5'd4, 5'd4, 5'd5),
              e_alu(3'd4, 32'hFFFF0000, 3'b010, 32'h0000FFFF, 32'd16, 6'b110000), 1'b1);
        issue(r_ins(6'b010001, 5'd6, 5'd2, 5'd1),
              e_alu(3'd6, 32'hFFFFFFFE, 3'b110, 32'd3, 32'd5, 6'b010001), 1'b1);
        // rd field 8 wraps to register 0 with a 3-bit register address.
        issue(r_ins(6'b100000, 5'd8, 5'd1, 5'd1),
              e_alu(3'd0, R0Z ? 32'd0 : 32'd1, 3'b100, 32'd5, 32'd5, 6'b100000), 1'b1);
        issue(r_ins(6'b100001, 5'd8, 5'd1, 5'd1),
              e_alu(3'd0, 32'd0, 3'b101, 32'd5, 32'd5, 6'b100001), 1'b1);

        e = e_alu(3'd1, 32'd5, 3'b101, 32'd5, 32'd5, 6'b100001);
        e.is_err = 1'b1;
        issue(r_ins(6'b111111, 5'd1, 5'd1, 5'd1), e, 1'b1);
        bus.instr_valid = 1'b1;
        bus.instr       = i_ins(5'd1, 16'hDEAD);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("busy_ready", 32'(bus.instr_ready), 32'd0);
            @(posedge clk);
        end
        #1 bus.instr_valid = 1'b0;

        issue(r_ins(6'b010000, 5'd7, 5'd1, 5'd2), e_alu(3'd7, 32'd9, 3'b000, 32'd5, 32'd3, 6'b010000), 1'b1);
        issue(r_ins(6'b110010, 5'd3, 5'd4, 5'd5),
              e_alu(3'd3, 32'hFFFFFFFF, 3'b010, 32'hFFFF0000, 32'd16, 6'b110010), 1'b1);
        issue(r_ins(6'b100011, 5'd5, 5'd1, 5'd2), e_alu(3'd5, 32'd1, 3'b000, 32'd5, 32'd3, 6'b100011), 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_before_reset", 32'(sb.size()), 32'd0);
        check("handshakes", 32'(hs), 32'(issued));

        issue(r_ins(6'b010000, 5'd3, 5'd1, 5'd2), e, 1'b0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.instr_ready), 32'd1);
        check("mid_rst_flags", 32'(bus.flags), 32'd0);
        check("mid_rst_alu_op", 32'(bus.alu_op), 32'd0);
        tb_sel = 3'd3;
        #1 check("mid_rst_r3", dbg_data, 32'd0);
        tb_sel = 3'd1;
        #1 check("mid_rst_r1", dbg_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);

        issue(i_ins(5'd0, 16'h1234), e_ldi(3'd0, R0Z ? 32'd0 : 32'h00001234, 3'b000), 1'b1);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain_final", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
